// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Build option: DATA_MEM_DEBUG_EN adds a side-band debug read port on the array.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_e;

  localparam int DMR_LATENCY_MAX = 7;
  localparam int DMR_CNT_W       = 3;

`ifdef DATA_MEM_DEBUG_EN
  localparam bit DMR_DEBUG_EN = 1'b1;
`else
  localparam bit DMR_DEBUG_EN = 1'b0;
`endif

endpackage

// File: rtl/data_mem_array.sv
// Word-organised single-port array: synchronous write, registered read.
// Build option: DATA_MEM_DEBUG_EN adds a combinational debug read port.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
`ifdef DATA_MEM_DEBUG_EN
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data,
`endif
  output logic [31:0]           rd_data
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // NOTE: the array and its read register have no reset on purpose, so the
  // storage maps onto block RAM instead of a huge bank of resettable flops.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rd_data <= mem[addr];
  end

`ifdef DATA_MEM_DEBUG_EN
  assign debug_data = mem[debug_addr];
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS core: programmable-latency access with stall.
// Build option: DATA_MEM_DEBUG_EN exposes debug_addr/debug_data on the array.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
`ifdef DATA_MEM_DEBUG_EN
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data,
`endif
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  mem_err
);

  localparam logic [DMR_CNT_W-1:0] CNT_LOAD = DMR_CNT_W'(LATENCY - 1);

  dmr_state_e            state;
  logic [DMR_CNT_W-1:0]  cnt;
  logic                  ren_q, wen_q, misalign_q, din_sel;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rd_data;
  logic                  req, access_now, arr_we, arr_re;

  // Upper address bits alias onto the array by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

  assign req        = mem_ren | mem_wen;
  // A reset arriving on the completion edge must also cancel the write.
  assign access_now = (state == DMR_BUSY) && (cnt == '0) && !rst;
  assign arr_we     = access_now && wen_q && !misalign_q;
  assign arr_re     = access_now && ren_q && !wen_q && !misalign_q;

  // NOTE: always_comb gives every output a default first, so no path can
  // leave mem_stall unassigned and infer a latch.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      DMR_IDLE: mem_stall = req;
      DMR_BUSY: mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DMR_IDLE;
      cnt        <= '0;
      mem_err    <= 1'b0;
      din_sel    <= 1'b0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        DMR_IDLE: begin
          mem_err <= 1'b0;
          if (req) begin
            ren_q      <= mem_ren;
            wen_q      <= mem_wen;
            addr_q     <= mem_addr[ADDR_WIDTH+1:2];
            wdata_q    <= mem_dout;
            misalign_q <= (mem_addr[1:0] != 2'b00);
            cnt        <= CNT_LOAD;
            state      <= DMR_BUSY;
          end
        end
        DMR_BUSY: begin
          if (cnt == '0) begin
            state   <= DMR_DONE;
            mem_err <= misalign_q || (ren_q && wen_q);
            din_sel <= ren_q && !wen_q && !misalign_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // The request still visible here is the one just completed.
          mem_err <= 1'b0;
          state   <= DMR_IDLE;
        end
      endcase
    end
  end

  // Read data is zero for writes and errors; otherwise the array's read
  // register, which only changes at the next clean read completion.
  assign mem_din = din_sel ? rd_data : 32'h0;

  data_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk        (clk),
    .we         (arr_we),
    .re         (arr_re),
    .addr       (addr_q),
    .wdata      (wdata_q),
`ifdef DATA_MEM_DEBUG_EN
    .debug_addr (debug_addr),
    .debug_data (debug_data),
`endif
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder at LATENCY=2 and one at LATENCY=1.
// Build option: DATA_MEM_DEBUG_EN also exercises the debug read port.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        ren, wen;
  logic [31:0] addr, wdata;

  logic [31:0] din_a, din_b, din;
  logic        stall_a, stall_b, stall;
  logic        err_a, err_b, err;
  logic        ren_a, wen_a, ren_b, wen_b;

  int compared   = 0;
  int mismatched = 0;
  int n;

`ifdef DATA_MEM_DEBUG_EN
  logic [9:0]  dbg_addr_a, dbg_addr_b;
  logic [31:0] dbg_data_a, dbg_data_b;
`endif

  always #5 clk = ~clk;

  assign ren_a = ren & ~sel;
  assign wen_a = wen & ~sel;
  assign ren_b = ren & sel;
  assign wen_b = wen & sel;
  assign din   = sel ? din_b   : din_a;
  assign stall = sel ? stall_b : stall_a;
  assign err   = sel ? err_b   : err_a;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .mem_ren    (ren_a),
    .mem_wen    (wen_a),
    .mem_addr   (addr),
    .mem_dout   (wdata),
`ifdef DATA_MEM_DEBUG_EN
    .debug_addr (dbg_addr_a),
    .debug_data (dbg_data_a),
`endif
    .mem_din    (din_a),
    .mem_stall  (stall_a),
    .mem_err    (err_a)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .mem_ren    (ren_b),
    .mem_wen    (wen_b),
    .mem_addr   (addr),
    .mem_dout   (wdata),
`ifdef DATA_MEM_DEBUG_EN
    .debug_addr (dbg_addr_b),
    .debug_data (dbg_data_b),
`endif
    .mem_din    (din_b),
    .mem_stall  (stall_b),
    .mem_err    (err_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request at a negedge, count stalled cycles, check the DONE cycle.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_stall, input logic [31:0] exp_din, input logic exp_err);
    @(negedge clk);
    ren = r; wen = w; addr = a; wdata = d;
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, n, exp_stall);
    check({tag, "_din"}, din, exp_din);
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    ren = 1'b0; wen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
`ifdef DATA_MEM_DEBUG_EN
    dbg_addr_a = '0; dbg_addr_b = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", {31'b0, stall_a}, 32'd0);
    check("reset_din",   din_a, 32'h0);
    check("reset_err",   {31'b0, err_a}, 32'd0);

    // LATENCY=2 unit
    access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0);
    @(negedge clk); #1;
    check("wr10_err_clears", {31'b0, err}, 32'd0);
    access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    @(negedge clk); #1;
    check("rd10_din_held", din, 32'hDEADBEEF);

    access("both30", 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 3, 32'h0, 1'b1);
    access("rd30",   1'b1, 1'b0, 32'h30, 32'h0, 3, 32'hA5A5A5A5, 1'b0);
    access("alias30", 1'b1, 1'b0, 32'h8000_0030, 32'h0, 3, 32'hA5A5A5A5, 1'b0);

    access("pre40", 1'b0, 1'b1, 32'h40, 32'h11111111, 3, 32'h0, 1'b0);

    // Request dropped after acceptance still commits.
    @(negedge clk);
    ren = 1'b0; wen = 1'b1; addr = 32'h50; wdata = 32'h00000077;
    @(negedge clk);
    wen = 1'b0; addr = '0; wdata = '0;
    #1;
    n = 0;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("drop50_busy_cycles", n, 32'd2);
    access("rd50", 1'b1, 1'b0, 32'h50, 32'h0, 3, 32'h00000077, 1'b0);

    // Reset mid-BUSY discards the write and clears outputs.
    @(negedge clk);
    ren = 1'b0; wen = 1'b1; addr = 32'h40; wdata = 32'h00000055;
    @(negedge clk);
    #1;
    check("rst_in_busy", {31'b0, stall}, 32'd1);
    rst = 1'b1; wen = 1'b0;
    @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_din",   din, 32'h0);
    check("rst_err",   {31'b0, err}, 32'd0);
    rst = 1'b0;
    access("rd40", 1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h11111111, 1'b0);

`ifdef DATA_MEM_DEBUG_EN
    access("wr08", 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 3, 32'h0, 1'b0);
    @(negedge clk);
    dbg_addr_a = 10'd2;
    #1;
    check("debug_data", dbg_data_a, 32'hCAFEF00D);
    check("debug_idle", {31'b0, stall}, 32'd0);
`endif

    // LATENCY=1 unit
    @(negedge clk);
    sel = 1'b1;
    access("b_wr20", 1'b0, 1'b1, 32'h20, 32'h12345678, 2, 32'h0, 1'b0);
    access("b_rd20", 1'b1, 1'b0, 32'h20, 32'h0, 2, 32'h12345678, 1'b0);
    access("b_mis22", 1'b1, 1'b0, 32'h22, 32'h0, 2, 32'h0, 1'b1);
    access("b_rd20b", 1'b1, 1'b0, 32'h20, 32'h0, 2, 32'h12345678, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
